// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM state type for the SPI register bridge.
package spi_reg_pkg;

    localparam int unsigned CMD_W               = 8;
    localparam int unsigned RW_BIT              = 7;
    localparam int unsigned ADDR_W              = 7;

    localparam int unsigned REG_STATUS          = 0;
    localparam int unsigned REG_LED             = 1;
    localparam int unsigned STATUS_BAD_ADDR_BIT = 0;
    localparam int unsigned STATUS_BTN_LSB      = 8;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } state_t;

endpackage

// File: rtl/spi_reg_bridge_button_debounce.sv
// Per-button synchroniser and stability-counter debouncer; reports pressed as 1.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned BTN_ACTIVE_LOW  = 1
) (
    input  logic CLK_50,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_pressed
);

    localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic        RELEASED = (BTN_ACTIVE_LOW != 0);

    logic [1:0]       sync;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Count consecutive cycles the synchronised pin differs from the accepted level.
    always_ff @(posedge CLK_50) begin
        if (rst) begin
            sync  <= {2{RELEASED}};
            level <= RELEASED;
            cnt   <= '0;
        end else begin
            sync <= {sync[0], btn_raw};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign btn_pressed = level ^ RELEASED;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave mapping command/data frames onto a small register bank
// with LED output, debounced button status and a sticky bad-address flag.
module spi_reg_bridge
    import spi_reg_pkg::*;
#(
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned N_REGS          = 8,
    parameter int unsigned N_LEDS          = 4,
    parameter int unsigned N_BUTTONS       = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned BTN_ACTIVE_LOW  = 1
) (
    input  logic                 CLK_50,
    input  logic                 rst,
    input  logic                 CS,
    input  logic                 SPI_CLK,
    input  logic                 SPI_incoming,
    output logic                 SPI_outgoing,
    input  logic [N_BUTTONS-1:0] Button,
    output logic [N_LEDS-1:0]    led,
    output logic                 wr_strobe,
    output logic [ADDR_W-1:0]    wr_addr
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned IDX_W = $clog2(N_REGS);
    localparam int unsigned AW1   = ADDR_W + 1;

    logic [1:0]        cs_sync, sck_sync, mosi_sync;
    logic              cs_prev, sck_prev;
    logic              cs_s, sck_s, mosi_s;
    logic              cs_fall, sck_rise, sck_fall;

    state_t            state, state_n;
    logic              cmd_done_c, frame_done_c;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CMD_W-2:0]  cmd_sh;
    logic [DATA_W-2:0] data_sh;
    logic [CMD_W-1:0]  cmd;
    logic [CMD_W-1:0]  cmd_in_c;
    logic [DATA_W-1:0] data_in_c;
    logic [ADDR_W-1:0] rd_addr_c, cmd_addr_c;
    logic [DATA_W-1:0] shift_out;
    logic [DATA_W-1:0] status_c, rd_data_c;
    logic [DATA_W-1:0] regs [N_REGS];
    logic              bad_addr;
    logic              wr_ok_c;
    logic [N_BUTTONS-1:0] btn_db;

    function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
        return AW1'(a) < AW1'(N_REGS);
    endfunction

    // Synchronisers; CS resets to "asserted" so a frame already in flight at
    // reset release never produces a falling edge until CS cycles high.
    always_ff @(posedge CLK_50) begin
        if (rst) begin
            cs_sync   <= '0;
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_prev   <= 1'b0;
            sck_prev  <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], CS};
            sck_sync  <= {sck_sync[0], SPI_CLK};
            mosi_sync <= {mosi_sync[0], SPI_incoming};
            cs_prev   <= cs_sync[1];
            sck_prev  <= sck_sync[1];
        end
    end

    assign cs_s     = cs_sync[1];
    assign sck_s    = sck_sync[1];
    assign mosi_s   = mosi_sync[1];
    assign cs_fall  = cs_prev & ~cs_s;
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;

    assign cmd_in_c   = {cmd_sh, mosi_s};
    assign data_in_c  = {data_sh, mosi_s};
    assign rd_addr_c  = cmd_in_c[ADDR_W-1:0];
    assign cmd_addr_c = cmd[ADDR_W-1:0];

    always_ff @(posedge CLK_50) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n      = state;
        cmd_done_c   = 1'b0;
        frame_done_c = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) state_n = CMD;
            end
            CMD: begin
                if (cs_s) begin
                    state_n = IDLE;
                end else if (sck_rise && bit_cnt == CNT_W'(CMD_W - 1)) begin
                    state_n    = DATA;
                    cmd_done_c = 1'b1;
                end
            end
            DATA: begin
                if (cs_s) begin
                    state_n = IDLE;
                end else if (sck_rise && bit_cnt == CNT_W'(DATA_W - 1)) begin
                    state_n      = CMD;
                    frame_done_c = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        status_c = '0;
        status_c[STATUS_BAD_ADDR_BIT] = bad_addr;
        status_c[STATUS_BTN_LSB +: N_BUTTONS] = btn_db;
    end

    always_comb begin
        rd_data_c = '0;
        if (addr_valid(rd_addr_c)) begin
            if (rd_addr_c == ADDR_W'(REG_STATUS)) rd_data_c = status_c;
            else                                  rd_data_c = regs[IDX_W'(rd_addr_c)];
        end
    end

    // Bit shifting, command latch and read-data preload.
    always_ff @(posedge CLK_50) begin
        if (rst) begin
            bit_cnt   <= '0;
            cmd_sh    <= '0;
            data_sh   <= '0;
            cmd       <= '0;
            shift_out <= '0;
        end else begin
            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (sck_rise) begin
                if (cmd_done_c || frame_done_c) bit_cnt <= '0;
                else                            bit_cnt <= bit_cnt + CNT_W'(1);
                if (state == CMD) cmd_sh  <= cmd_in_c[CMD_W-2:0];
                else              data_sh <= data_in_c[DATA_W-2:0];
            end

            if (cmd_done_c) begin
                cmd       <= cmd_in_c;
                shift_out <= cmd_in_c[RW_BIT] ? '0 : rd_data_c;
            end else if (state == DATA && sck_fall) begin
                shift_out <= {shift_out[DATA_W-2:0], 1'b0};
            end
        end
    end

    // MISO moves only on SCK fall, and is forced low whenever no frame is active.
    always_ff @(posedge CLK_50) begin
        if (rst) begin
            SPI_outgoing <= 1'b0;
        end else if (cs_s || state == IDLE) begin
            SPI_outgoing <= 1'b0;
        end else if (sck_fall) begin
            SPI_outgoing <= (state == DATA) ? shift_out[DATA_W-1] : 1'b0;
        end
    end

    assign wr_ok_c = cmd[RW_BIT] && addr_valid(cmd_addr_c)
                     && (cmd_addr_c != ADDR_W'(REG_STATUS));

    always_ff @(posedge CLK_50) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_REGS; i++) regs[i] <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            bad_addr  <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            if (frame_done_c) begin
                if (wr_ok_c) begin
                    regs[IDX_W'(cmd_addr_c)] <= data_in_c;
                    wr_strobe                <= 1'b1;
                    wr_addr                  <= cmd_addr_c;
                end
                if (!cmd[RW_BIT] && cmd_addr_c == ADDR_W'(REG_STATUS)) bad_addr <= 1'b0;
                if (!addr_valid(cmd_addr_c))                           bad_addr <= 1'b1;
            end
        end
    end

    assign led = regs[IDX_W'(REG_LED)][N_LEDS-1:0];

    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
        ) u_debounce (
            .CLK_50      (CLK_50),
            .rst         (rst),
            .btn_raw     (Button[g]),
            .btn_pressed (btn_db[g])
        );
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: SPI frames driven at CLK_50/8, results
// checked against hand-computed values.
module tb_spi_reg_bridge;

    logic       CLK_50 = 1'b0;
    logic       rst;
    logic       CS;
    logic       SPI_CLK;
    logic       SPI_incoming;
    logic       SPI_outgoing;
    logic [1:0] Button;
    logic [3:0] led;
    logic       wr_strobe;
    logic [6:0] wr_addr;

    int         total = 0;
    int         bad   = 0;
    int         strobe_cnt = 0;
    logic [6:0] strobe_addr = '0;
    logic [3:0] strobe_led  = '0;

    always #5 CLK_50 = ~CLK_50;

    spi_reg_bridge #(
        .DATA_W          (16),
        .N_REGS          (8),
        .N_LEDS          (4),
        .N_BUTTONS       (2),
        .DEBOUNCE_CYCLES (16),
        .BTN_ACTIVE_LOW  (1)
    ) dut (
        .CLK_50       (CLK_50),
        .rst          (rst),
        .CS           (CS),
        .SPI_CLK      (SPI_CLK),
        .SPI_incoming (SPI_incoming),
        .SPI_outgoing (SPI_outgoing),
        .Button       (Button),
        .led          (led),
        .wr_strobe    (wr_strobe),
        .wr_addr      (wr_addr)
    );

    // Record every strobe cycle together with the outputs visible alongside it.
    always @(negedge CLK_50) begin
        if (wr_strobe === 1'b1) begin
            strobe_cnt  = strobe_cnt + 1;
            strobe_addr = wr_addr;
            strobe_led  = led;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK_50);
    endtask

    task automatic cs_begin();
        CS = 1'b0;
        wait_clk(4);
    endtask

    task automatic cs_end();
        wait_clk(4);
        CS = 1'b1;
        wait_clk(8);
    endtask

    // Shift n bits MSB first; MISO is captured at the moment SCK rises.
    task automatic shift(input logic [15:0] tx, input int n, output logic [15:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            SPI_CLK      = 1'b0;
            SPI_incoming = tx[i];
            wait_clk(4);
            rx      = {rx[14:0], SPI_outgoing};
            SPI_CLK = 1'b1;
            wait_clk(4);
        end
        SPI_CLK = 1'b0;
    endtask

    task automatic frame(input logic [7:0] c, input logic [15:0] d,
                         output logic [15:0] rxc, output logic [15:0] rxd);
        shift({8'h00, c}, 8, rxc);
        shift(d, 16, rxd);
    endtask

    task automatic xfer(input logic [7:0] c, input logic [15:0] d, output logic [15:0] rxd);
        logic [15:0] rxc;
        cs_begin();
        frame(c, d, rxc, rxd);
        cs_end();
    endtask

    initial begin
        logic [15:0] rx, rxc;
        int          s0;

        rst = 1'b1; CS = 1'b1; SPI_CLK = 1'b0; SPI_incoming = 1'b0; Button = 2'b11;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(5);

        chk("reset_led", 32'(led), 32'h0);
        chk("reset_miso", 32'(SPI_outgoing), 32'h0);
        chk("reset_strobe", 32'(wr_strobe), 32'h0);
        chk("reset_wr_addr", 32'(wr_addr), 32'h0);

        // LED write
        s0 = strobe_cnt;
        xfer(8'h81, 16'h000A, rx);
        chk("led_after_write", 32'(led), 32'hA);
        chk("led_write_strobes", 32'(strobe_cnt - s0), 32'd1);
        chk("led_write_strobe_addr", 32'(strobe_addr), 32'd1);
        chk("led_with_strobe", 32'(strobe_led), 32'hA);
        chk("miso_idle", 32'(SPI_outgoing), 32'h0);

        // Read back LED, MISO quiet during command
        cs_begin();
        frame(8'h01, 16'h0000, rxc, rx);
        cs_end();
        chk("read_led_cmd_miso", 32'(rxc), 32'h0);
        chk("read_led", 32'(rx), 32'h000A);

        // Back-to-back write then read in one CS
        cs_begin();
        frame(8'h82, 16'hBEEF, rxc, rx);
        frame(8'h02, 16'h0000, rxc, rx);
        cs_end();
        chk("b2b_read_reg2", 32'(rx), 32'hBEEF);
        chk("b2b_strobes", 32'(strobe_cnt - s0), 32'd2);
        chk("b2b_wr_addr", 32'(wr_addr), 32'd2);

        // Abort after 20 bits
        s0 = strobe_cnt;
        cs_begin();
        shift(16'h0082, 8, rxc);
        shift(16'h0123, 12, rx);
        cs_end();
        chk("abort_no_strobe", 32'(strobe_cnt - s0), 32'd0);
        xfer(8'h02, 16'h0000, rx);
        chk("abort_reg2_kept", 32'(rx), 32'hBEEF);
        chk("abort_wr_addr", 32'(wr_addr), 32'd2);

        // Bad address handling
        xfer(8'h8A, 16'h1234, rx);
        chk("bad_wr_no_strobe", 32'(strobe_cnt - s0), 32'd0);
        chk("bad_wr_led", 32'(led), 32'hA);
        xfer(8'h02, 16'h0000, rx);
        chk("bad_wr_reg2", 32'(rx), 32'hBEEF);
        xfer(8'h00, 16'h0000, rx);
        chk("status_bad_set", 32'(rx), 32'h0001);
        xfer(8'h00, 16'h0000, rx);
        chk("status_bad_cleared", 32'(rx), 32'h0000);
        xfer(8'h0A, 16'h0000, rx);
        chk("bad_read_zero", 32'(rx), 32'h0000);
        xfer(8'h00, 16'h0000, rx);
        chk("status_bad_read_set", 32'(rx), 32'h0001);
        xfer(8'h80, 16'hFFFF, rx);
        chk("status_write_no_strobe", 32'(strobe_cnt - s0), 32'd0);
        xfer(8'h00, 16'h0000, rx);
        chk("status_after_ro_write", 32'(rx), 32'h0000);

        // Button debounce
        Button = 2'b10;
        wait_clk(20);
        xfer(8'h00, 16'h0000, rx);
        chk("btn0_pressed", 32'(rx), 32'h0100);
        Button = 2'b11;
        wait_clk(30);
        xfer(8'h00, 16'h0000, rx);
        chk("btn0_released", 32'(rx), 32'h0000);
        Button = 2'b10;
        wait_clk(5);
        Button = 2'b11;
        wait_clk(30);
        xfer(8'h00, 16'h0000, rx);
        chk("btn0_glitch", 32'(rx), 32'h0000);

        // Reset in the data phase of an LED write
        s0 = strobe_cnt;
        cs_begin();
        shift(16'h0081, 8, rxc);
        shift(16'h0000, 8, rx);
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_miso", 32'(SPI_outgoing), 32'h0);
        chk("rst_wr_addr", 32'(wr_addr), 32'h0);
        shift(16'h000F, 8, rx);
        chk("rst_tail_miso", 32'(rx), 32'h0);
        cs_end();
        chk("rst_no_commit", 32'(strobe_cnt - s0), 32'd0);
        chk("rst_led_after_cs", 32'(led), 32'h0);
        xfer(8'h01, 16'h0000, rx);
        chk("rst_reg1_zero", 32'(rx), 32'h0000);
        xfer(8'h02, 16'h0000, rx);
        chk("rst_reg2_zero", 32'(rx), 32'h0000);
        xfer(8'h81, 16'h0005, rx);
        chk("post_rst_led", 32'(led), 32'h5);
        chk("post_rst_strobe", 32'(strobe_cnt - s0), 32'd1);
        chk("post_rst_wr_addr", 32'(wr_addr), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Parametrised SPI slave (mode 0, MSB first) that maps SPI frames onto a small register bank in the CLK_50 domain.
- Replaces the ad-hoc SPI/LED/button wiring in the board top level: debounced button status is readable over SPI, and LEDs are driven from a writable register.
- Register count, data width, LED and button counts are all configurable; multiple frames per CS assertion are supported.
- Instantiated directly under the board top level.

Parameters:
- DATA_W, 16, data bits per frame; must be >= 8+N_BUTTONS and >= N_LEDS.
- N_REGS, 8, register count; must be between 2 and 128.
- N_LEDS, 4, width of led output.
- N_BUTTONS, 2, button input count.
- DEBOUNCE_CYCLES, 500000, CLK_50 cycles a button must be stable to be accepted (10 ms).
- BTN_ACTIVE_LOW, 1, 1 means a pressed button reads 0 at the pin.

Ports:
- CLK_50 input 1 system clock; all logic is in this domain; must be >= 4x SPI_CLK.
- rst input 1 synchronous, active-high reset.
- CS input 1 SPI chip select, active low, asynchronous to CLK_50.
- SPI_CLK input 1 SPI clock, idle low, asynchronous.
- SPI_incoming input 1 MOSI.
- SPI_outgoing output 1 MISO.
- Button input N_BUTTONS raw button pins.
- led output N_LEDS, equal to REG_LED[N_LEDS-1:0].
- wr_strobe output 1 one-cycle pulse on each committed register write.
- wr_addr output 7 address of the last committed write.

Behaviour:
- Input synchronisation:
  - CS, SPI_CLK and SPI_incoming each pass through 2-FF synchronisers.
  - SCK rise and fall are one-cycle pulses derived from the synchronised SPI_CLK.
- Frame format: 8-bit command, then DATA_W data bits.
  - Command bit7: 1 = write, 0 = read. Bits 6:0 = address.
  - MOSI is sampled on SCK rise. MISO changes only on SCK fall.
- FSM states: IDLE, CMD, DATA.
  - IDLE -> CMD on synchronised CS falling; bit counter cleared.
  - CMD -> DATA on the 8th SCK rise; command latched.
  - For a read, the shift-out register loads the addressed register on that same cycle. Its MSB drives MISO on the next SCK fall.
  - DATA -> CMD on the DATA_W-th SCK rise, allowing back-to-back frames within one CS. Write commit happens on that same transition.
  - Any state -> IDLE when CS goes high. A partial frame commits nothing.
- Write commit:
  - Register and wr_addr are updated, and wr_strobe is pulsed, in the CLK_50 cycle after the final SCK rise pulse.
  - led follows on that same cycle.
- Address map:
  - 0 = STATUS, read-only: bit0 = bad_addr sticky; bits [8 +: N_BUTTONS] = debounced buttons, pressed = 1; other bits 0.
  - 1 = LED, read/write.
  - 2..N_REGS-1 = scratch, read/write.
- Writes to STATUS are ignored, and no wr_strobe is issued.
- Address >= N_REGS: a read returns all 0 and a write is dropped. Either case sets bad_addr.
- A completed read of STATUS clears bad_addr at the final SCK rise of that frame. If a bad address arrives in the same cycle, the set wins.
- MISO is 0 in IDLE, in CMD, and when CS is high.
- Buttons: each button is synchronised, then debounced by a counter. The counter resets on any change and accepts the new level once stable for DEBOUNCE_CYCLES.
- Reset values: all registers 0, led 0, SPI_outgoing 0, wr_strobe 0, wr_addr 0, FSM IDLE, debounced buttons = released.
- After reset, the FSM stays in IDLE until a fresh CS falling edge. A frame already in progress is ignored until CS goes high then low.

Decomposition:
- Package spi_reg_pkg:
  - CMD_W=8, RW_BIT=7, ADDR_W=7.
  - REG_STATUS=0, REG_LED=1, STATUS_BAD_ADDR_BIT=0, STATUS_BTN_LSB=8.
  - FSM state enum {IDLE, CMD, DATA}.
- Sub-module button_debounce, one instance per button. Parameters DEBOUNCE_CYCLES and BTN_ACTIVE_LOW; ports CLK_50, rst, btn_raw, btn_pressed.

Test Plan (DATA_W=16, N_REGS=8, N_LEDS=4, DEBOUNCE_CYCLES=16, SPI_CLK = CLK_50/8):
- Write LED: CS low, send 0x81 then 0x000A, CS high -> led=4'b1010 and a single wr_strobe with wr_addr=1, both one cycle after the 24th SCK rise.
- Read-back: send 0x01 then 16 dummy bits -> MISO shifts 0x000A MSB first, each bit stable at SCK rise. Send 0x82/0xBEEF then 0x02 in one CS -> second frame returns 0xBEEF.
- Abort: write to reg2 with CS raised after 20 bits -> reg2 unchanged, no wr_strobe; the next full frame operates normally.
- Bad address: write 0x8A/0x1234 -> no register changes, no wr_strobe. Read STATUS returns bit0=1; a second read returns bit0=0.
- Button: hold Button[0]=0 for 20 cycles -> STATUS[8]=1. A 5-cycle glitch -> STATUS unchanged.
- Reset mid-frame: assert rst during the data phase of write 0x81/0x000F -> led=0, all registers 0, MISO=0, no commit. The rest of that CS window is ignored; the next CS frame works.
